// File: rtl/snake_fb_pkg.sv
// Shared constants, state encoding and tile-origin helper for the snake
// framebuffer writer (fb_tile_painter and fb_tile_addr_gen).
package snake_fb_pkg;

   localparam int H_RES      = 640;
   localparam int V_RES      = 480;
   localparam int TILE       = 16;
   localparam int ADDR_W     = 19;
   localparam int DATA_W     = 8;

   localparam int TILE_LOG2  = $clog2(TILE);
   localparam int TILE_COLS  = H_RES / TILE;
   localparam int TILE_ROWS  = V_RES / TILE;
   localparam int FB_WORDS   = H_RES * V_RES;
   localparam int ROW_STRIDE = TILE * H_RES;
   localparam int IDX_W      = 6;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PAINT = 3'd1,
      CLEAR = 3'd2,
      DONE  = 3'd3,
      REJ   = 3'd4
   } fb_state_t;

   // Top-left pixel address of tile (col,row), built from shifted row-stride
   // partial sums so no general multiplier is needed.
   function automatic logic [ADDR_W-1:0] tile_base(input logic [IDX_W-1:0] col,
                                                    input logic [IDX_W-1:0] row);
      logic [ADDR_W-1:0] acc;
      acc = ADDR_W'(col) << TILE_LOG2;
      for (int i = 0; i < IDX_W; i++) begin
         if (row[i]) acc = acc + (ADDR_W'(ROW_STRIDE) << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/fb_tile_addr_gen.sv
// Raster-order address generator for a rectangular framebuffer region.
// px/py counters walk the region; the line base advances by H_RES per row and
// the address is either incremented or reloaded from the next line base.
// With full=1 at start the region is the whole screen (used by the clear path).
module fb_tile_addr_gen
   import snake_fb_pkg::*;
(
   input  logic              iclk,
   input  logic              iRST_n,
   input  logic              start,
   input  logic              step,
   input  logic              full,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   logic [9:0]        px;
   logic [8:0]        py;
   logic [ADDR_W-1:0] line_base;
   logic              full_q;
   logic [9:0]        px_max;
   logic [8:0]        py_max;

   // Region extent selected by the mode latched at start.
   always_comb begin
      px_max = full_q ? 10'(H_RES - 1) : 10'(TILE - 1);
      py_max = full_q ? 9'(V_RES - 1)  : 9'(TILE - 1);
   end

   assign last = (px == px_max) && (py == py_max);

   // Counters and accumulators; they hold on the last pixel so the address
   // never runs past the end of the region.
   always_ff @(posedge iclk or negedge iRST_n) begin
      if (!iRST_n) begin
         px        <= '0;
         py        <= '0;
         line_base <= '0;
         addr      <= '0;
         full_q    <= 1'b0;
      end else if (start) begin
         px        <= '0;
         py        <= '0;
         line_base <= base;
         addr      <= base;
         full_q    <= full;
      end else if (step && !last) begin
         if (px == px_max) begin
            px        <= '0;
            py        <= py + 9'd1;
            line_base <= line_base + ADDR_W'(H_RES);
            addr      <= line_base + ADDR_W'(H_RES);
         end else begin
            px   <= px + 10'd1;
            addr <= addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/fb_tile_painter.sv
// Framebuffer tile painter: turns "paint tile (col,row) with colour" requests
// into one framebuffer write per clock in raster order within the tile.
// Optional build macro FB_CLEAR_EN adds a full-screen clear request (iclear=1).
// Without it, iclear is accepted on the port but has no effect.
module fb_tile_painter
   import snake_fb_pkg::*;
(
   input  logic              iclk,
   input  logic              iRST_n,
   input  logic              ireq_valid,
   output logic              oreq_ready,
   input  logic              iclear,
   input  logic [IDX_W-1:0]  icol,
   input  logic [IDX_W-1:0]  irow,
   input  logic [DATA_W-1:0] icolor,
   output logic              owren,
   output logic [ADDR_W-1:0] oaddr,
   output logic [DATA_W-1:0] odata,
   output logic              odone,
   output logic              oerr
);

   fb_state_t         state, state_nxt;
   logic              owren_nxt, odone_nxt, oerr_nxt;
   logic              gen_start, gen_step, gen_full, gen_last;
   logic              load_color;
   logic              tile_in_range;
   logic [ADDR_W-1:0] gen_base;

   assign oreq_ready    = (state == IDLE);
   assign tile_in_range = (icol < IDX_W'(TILE_COLS)) && (irow < IDX_W'(TILE_ROWS));

`ifdef FB_CLEAR_EN
   assign gen_full = iclear;
   assign gen_base = iclear ? '0 : tile_base(icol, irow);
`else
   logic unused_clear;
   assign unused_clear = iclear;
   assign gen_full     = 1'b0;
   assign gen_base     = tile_base(icol, irow);
`endif

   fb_tile_addr_gen u_addr_gen (
      .iclk   (iclk),
      .iRST_n (iRST_n),
      .start  (gen_start),
      .step   (gen_step),
      .full   (gen_full),
      .base   (gen_base),
      .addr   (oaddr),
      .last   (gen_last)
   );

   // State register.
   always_ff @(posedge iclk or negedge iRST_n) begin
      if (!iRST_n) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next state and next values of the registered write/status outputs.
   always_comb begin
      state_nxt  = state;
      owren_nxt  = 1'b0;
      odone_nxt  = 1'b0;
      oerr_nxt   = 1'b0;
      gen_start  = 1'b0;
      gen_step   = 1'b0;
      load_color = 1'b0;
      case (state)
         IDLE: begin
            if (ireq_valid) begin
`ifdef FB_CLEAR_EN
               if (iclear) begin
                  state_nxt  = CLEAR;
                  gen_start  = 1'b1;
                  load_color = 1'b1;
                  owren_nxt  = 1'b1;
               end else
`endif
               if (tile_in_range) begin
                  state_nxt  = PAINT;
                  gen_start  = 1'b1;
                  load_color = 1'b1;
                  owren_nxt  = 1'b1;
               end else begin
                  state_nxt  = REJ;
                  oerr_nxt   = 1'b1;
               end
            end
         end
         PAINT: begin
            gen_step = 1'b1;
            if (gen_last) begin
               state_nxt = DONE;
               odone_nxt = 1'b1;
            end else begin
               owren_nxt = 1'b1;
            end
         end
`ifdef FB_CLEAR_EN
         CLEAR: begin
            gen_step = 1'b1;
            if (gen_last) begin
               state_nxt = DONE;
               odone_nxt = 1'b1;
            end else begin
               owren_nxt = 1'b1;
            end
         end
`endif
         DONE:    state_nxt = IDLE;
         REJ:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered write enable, status pulses and the colour captured at acceptance.
   always_ff @(posedge iclk or negedge iRST_n) begin
      if (!iRST_n) begin
         owren <= 1'b0;
         odone <= 1'b0;
         oerr  <= 1'b0;
         odata <= '0;
      end else begin
         owren <= owren_nxt;
         odone <= odone_nxt;
         oerr  <= oerr_nxt;
         if (load_color) odata <= icolor;
      end
   end

endmodule

// File: tb/tb_fb_tile_painter.sv
// Scoreboard bench for fb_tile_painter: the driver pushes the expected write,
// done and error events (with their cycle numbers) for each accepted request;
// a monitor on the falling edge pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_fb_tile_painter;

   localparam int SCR_W = 640;
   localparam int SCR_H = 480;
   localparam int T     = 16;

   logic        iclk = 1'b0;
   logic        iRST_n = 1'b0;
   logic        ireq_valid = 1'b0;
   logic        iclear = 1'b0;
   logic [5:0]  icol = '0;
   logic [5:0]  irow = '0;
   logic [7:0]  icolor = '0;
   logic        oreq_ready, owren, odone, oerr;
   logic [18:0] oaddr;
   logic [7:0]  odata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int next_ready = -1;
   bit held = 1'b0;
   int last_k = 0;

   typedef struct {
      int kind;   // 0 write, 1 done, 2 error
      int cyc;
      int addr;
      int data;
   } exp_t;
   exp_t sb[$];

   int   m_kind;
   exp_t m_e;

   fb_tile_painter dut (
      .iclk       (iclk),
      .iRST_n     (iRST_n),
      .ireq_valid (ireq_valid),
      .oreq_ready (oreq_ready),
      .iclear     (iclear),
      .icol       (icol),
      .irow       (irow),
      .icolor     (icolor),
      .owren      (owren),
      .oaddr      (oaddr),
      .odata      (odata),
      .odone      (odone),
      .oerr       (oerr)
   );

   always #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference model: a request accepted on the edge closing cycle k.
   task automatic push_model(input int col, input int row, input int color, input int k);
      exp_t e;
      if (col < SCR_W / T && row < SCR_H / T) begin
         for (int py = 0; py < T; py++) begin
            for (int px = 0; px < T; px++) begin
               e.kind = 0;
               e.cyc  = k + 1 + py * T + px;
               e.addr = (row * T + py) * SCR_W + col * T + px;
               e.data = color;
               sb.push_back(e);
            end
         end
         e.kind = 1; e.cyc = k + T * T + 1; e.addr = 0; e.data = 0;
         sb.push_back(e);
         next_ready = k + T * T + 2;
      end else begin
         e.kind = 2; e.cyc = k + 1; e.addr = 0; e.data = 0;
         sb.push_back(e);
         next_ready = k + 2;
      end
   endtask

   task automatic scramble();
      icol   = 6'($urandom_range(0, 63));
      irow   = 6'($urandom_range(0, 63));
      icolor = 8'($urandom);
`ifdef FB_CLEAR_EN
      iclear = 1'b0;
`else
      iclear = 1'($urandom);
`endif
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!oreq_ready) begin
         if (ireq_valid) scramble();
         @(negedge iclk);
         w++;
         if (w > 2000) begin
            errors++;
            $display("FAIL ready_timeout actual=0 required=1 at cycle %0d", cyc);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "ready timeout");
         end
      end
      if (held) chk("ready_cycle", cyc, next_ready);
   endtask

   task automatic accept_req(input int col, input int row, input int color);
      icol   = 6'(col);
      irow   = 6'(row);
      icolor = 8'(color);
`ifdef FB_CLEAR_EN
      iclear = 1'b0;
`else
      iclear = 1'($urandom);
`endif
      ireq_valid = 1'b1;
      last_k = cyc;
      push_model(col, row, color, cyc);
      @(posedge iclk);
      @(negedge iclk);
   endtask

   task automatic issue(input int col, input int row, input int color, input bit hold_after);
      wait_ready();
      accept_req(col, row, color);
      held = hold_after;
      scramble();
      if (!hold_after) begin
         ireq_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge iclk);
      end
   endtask

   // Monitor: every write/done/error the DUT presents must match the queue head.
   always @(negedge iclk) begin
      if (iRST_n) begin
         if (int'(owren) + int'(odone) + int'(oerr) > 1) begin
            checks++; errors++;
            $display("FAIL multi_event owren=%0d odone=%0d oerr=%0d required at most one", owren, odone, oerr);
         end
         if (owren) begin
            checks++;
            if (int'(oaddr) >= SCR_W * SCR_H) begin
               errors++;
               $display("FAIL addr_range actual=%0d required<%0d", oaddr, SCR_W * SCR_H);
            end
         end
         if (owren || odone || oerr) begin
            m_kind = owren ? 0 : (odone ? 1 : 2);
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%0d required=none", m_kind, cyc, oaddr);
            end else begin
               m_e = sb.pop_front();
               if (m_e.kind != m_kind || m_e.cyc != cyc ||
                   (m_kind == 0 && (int'(oaddr) != m_e.addr || int'(odata) != m_e.data))) begin
                  errors++;
                  $display("FAIL event actual kind=%0d cyc=%0d addr=%0d data=%0d required kind=%0d cyc=%0d addr=%0d data=%0d",
                           m_kind, cyc, oaddr, odata, m_e.kind, m_e.cyc, m_e.addr, m_e.data);
               end
            end
         end else begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
               m_e = sb.pop_front();
               checks++; errors++;
               $display("FAIL missing_event actual=none required kind=%0d cyc=%0d addr=%0d", m_e.kind, m_e.cyc, m_e.addr);
            end
         end
      end
   end

   initial begin
      int w;
      // Reset state.
      iRST_n = 1'b0;
      repeat (3) @(negedge iclk);
      chk("rst_owren", int'(owren), 0);
      chk("rst_oaddr", int'(oaddr), 0);
      chk("rst_odone", int'(odone), 0);
      chk("rst_oerr",  int'(oerr),  0);
      chk("rst_odata", int'(odata), 0);
      iRST_n = 1'b1;
      @(negedge iclk);
      chk("ready_after_reset", int'(oreq_ready), 1);

      // Directed tiles: top-left, bottom-right, out of range.
      issue(0, 0, 8'h1F, 1'b0);
      issue(39, 29, 8'hA5, 1'b0);
      issue(40, 0, 8'h33, 1'b0);
      issue(0, 30, 8'h44, 1'b0);

      // Back-to-back with valid held; inputs scrambled while busy.
      issue(5, 7, 8'h5A, 1'b1);
      issue(12, 3, 8'hC3, 1'b1);
      issue(63, 2, 8'h11, 1'b1);
      issue(33, 20, 8'h7E, 1'b0);

      // Randomized requests, including out-of-range and held valid.
      for (int i = 0; i < 14; i++) begin
         issue($urandom_range(0, 42), $urandom_range(0, 32), $urandom_range(0, 255),
               (i == 13) ? 1'b0 : 1'($urandom));
      end

      // Reset asserted while write 100 of a tile is on the port.
      wait_ready();
      accept_req(20, 10, 8'h99);
      ireq_valid = 1'b0;
      held = 1'b0;
      repeat (99) @(negedge iclk);
      chk("write100_cycle", cyc, last_k + 100);
      iRST_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_owren", int'(owren), 0);
      chk("midrst_odone", int'(odone), 0);
      chk("midrst_oaddr", int'(oaddr), 0);
      repeat (2) @(negedge iclk);
      iRST_n = 1'b1;
      @(negedge iclk);
      chk("ready_after_midrst", int'(oreq_ready), 1);
      repeat (300) @(negedge iclk);

      // One more tile after the mid-operation reset.
      issue(1, 1, 8'hE7, 1'b0);

      // Drain the scoreboard within a bounded time.
      w = 0;
      while (sb.size() > 0 && w < 1000) begin
         @(negedge iclk);
         w++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      repeat (5) @(negedge iclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
